// File: rtl/dht11_uart_formatter.sv
// Formats latched DHT11 humidity/temperature bytes as the 13-byte ASCII frame
// "H:hh% T:ttC\r\n" and pushes it into a TX FIFO under a push/full handshake.
module dht11_uart_formatter #(
  parameter int unsigned CLAMP_MAX = 99,
  parameter bit          LEAD_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_send,
  input  logic        i_valid,
  input  logic [15:0] i_humid,
  input  logic [15:0] i_temp,
  input  logic        i_full,
  output logic        o_push,
  output logic [7:0]  o_wdata,
  output logic        o_busy,
  output logic        o_drop
);

  typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

  localparam logic [7:0] ClampVal = 8'(CLAMP_MAX);

  state_e     state_q, state_d;
  logic [6:0] h_rem_q, h_rem_d, t_rem_q, t_rem_d;
  logic [3:0] h_tens_q, h_tens_d, t_tens_q, t_tens_d;
  logic [3:0] idx_q, idx_d;
  logic       v_q, v_d;

  logic [7:0] h_clamp, t_clamp;
  logic [7:0] h_d1, h_d0, t_d1, t_d0;

  // Decimal fraction bytes are not part of the frame.
  logic unused_frac;
  assign unused_frac = ^{i_humid[7:0], i_temp[7:0], h_clamp[7], t_clamp[7]};

  assign h_clamp = (i_humid[15:8] > ClampVal) ? ClampVal : i_humid[15:8];
  assign t_clamp = (i_temp[15:8] > ClampVal) ? ClampVal : i_temp[15:8];

  assign o_busy = (state_q != StIdle);
  assign o_drop = i_send && (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    h_rem_d  = h_rem_q;
    t_rem_d  = t_rem_q;
    h_tens_d = h_tens_q;
    t_tens_d = t_tens_q;
    idx_d    = idx_q;
    v_d      = v_q;
    o_push   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_send) begin
          h_rem_d  = h_clamp[6:0];
          t_rem_d  = t_clamp[6:0];
          h_tens_d = 4'd0;
          t_tens_d = 4'd0;
          idx_d    = 4'd0;
          v_d      = i_valid;
          state_d  = i_valid ? StConv : StSend;
        end
      end
      StConv: begin
        if (h_rem_q < 7'd10 && t_rem_q < 7'd10) begin
          state_d = StSend;
        end else begin
          if (h_rem_q >= 7'd10) begin
            h_rem_d  = h_rem_q - 7'd10;
            h_tens_d = h_tens_q + 4'd1;
          end
          if (t_rem_q >= 7'd10) begin
            t_rem_d  = t_rem_q - 7'd10;
            t_tens_d = t_tens_q + 4'd1;
          end
        end
      end
      StSend: begin
        o_push = !i_full;
        if (o_push) begin
          if (idx_q == 4'd12) state_d = StIdle;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit bytes; an invalid reading prints dashes regardless of the latched values.
  always_comb begin
    h_d1 = 8'h30 + {4'h0, h_tens_q};
    t_d1 = 8'h30 + {4'h0, t_tens_q};
    h_d0 = 8'h30 + {1'b0, h_rem_q};
    t_d0 = 8'h30 + {1'b0, t_rem_q};
    if (!LEAD_ZERO && h_tens_q == 4'd0) h_d1 = 8'h20;
    if (!LEAD_ZERO && t_tens_q == 4'd0) t_d1 = 8'h20;
    if (!v_q) begin
      h_d1 = 8'h2d;
      h_d0 = 8'h2d;
      t_d1 = 8'h2d;
      t_d0 = 8'h2d;
    end
  end

  always_comb begin
    o_wdata = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        4'd0:    o_wdata = 8'h48;
        4'd1:    o_wdata = 8'h3a;
        4'd2:    o_wdata = h_d1;
        4'd3:    o_wdata = h_d0;
        4'd4:    o_wdata = 8'h25;
        4'd5:    o_wdata = 8'h20;
        4'd6:    o_wdata = 8'h54;
        4'd7:    o_wdata = 8'h3a;
        4'd8:    o_wdata = t_d1;
        4'd9:    o_wdata = t_d0;
        4'd10:   o_wdata = 8'h43;
        4'd11:   o_wdata = 8'h0d;
        4'd12:   o_wdata = 8'h0a;
        default: o_wdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      h_rem_q  <= 7'd0;
      t_rem_q  <= 7'd0;
      h_tens_q <= 4'd0;
      t_tens_q <= 4'd0;
      idx_q    <= 4'd0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_rem_q  <= h_rem_d;
      t_rem_q  <= t_rem_d;
      h_tens_q <= h_tens_d;
      t_tens_q <= t_tens_d;
      idx_q    <= idx_d;
      v_q      <= v_d;
    end
  end

endmodule
